// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_rr_pick4.sv
// Round-robin picker: first requesting channel at or above ptr, wrapping 3->0.
// Latency: combinational.
// Backpressure: none; found=0 when no channel requests.
module rr_pick4
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] cand;

    // Scan offsets high-to-low so the smallest offset from ptr is the last write and wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Round-robin scan of four mux channels: holds S1/S0 for DWELL cycles, then samples y.
// Latency: grant 1 cycle after the arbitration edge; y_valid DWELL+1 cycles after it.
// Backpressure: none; req is only looked at on arbitration edges, a dwell always completes.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    input  logic              y_in,
    output logic              S1,
    output logic              S0,
    output logic [NUM_CH-1:0] grant,
    output logic              busy,
    output logic              y_q,
    output logic [SEL_W-1:0]  y_ch,
    output logic              y_valid
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              yq_d;
    logic [SEL_W-1:0]  ych_d;
    logic              yvld_d;

    logic              dwell_done;
    logic [SEL_W-1:0]  pick_ptr;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;

    assign dwell_done = (state_q == HOLD) && (cnt_q == '0);

    // At the end of a dwell the picker already sees the advanced pointer,
    // which lets the next grant start without an idle bubble.
    assign pick_ptr = dwell_done ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        yq_d    = y_q;
        ych_d   = y_ch;
        yvld_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && pick_found) begin
                    state_d = HOLD;
                    sel_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                    cnt_d   = CNT_LOAD;
                end else begin
                    grant_d = '0;
                end
            end
            HOLD: begin
                if (!dwell_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    yq_d   = y_in;
                    ych_d  = sel_q;
                    yvld_d = 1'b1;
                    ptr_d  = pick_ptr;
                    if (en && pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = onehot(pick_idx);
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            y_q     <= 1'b0;
            y_ch    <= '0;
            y_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            y_q     <= yq_d;
            y_ch    <= ych_d;
            y_valid <= yvld_d;
        end
    end

    assign S1    = sel_q[1];
    assign S0    = sel_q[0];
    assign grant = grant_q;
    assign busy  = (state_q == HOLD);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench over four sequencer instances (DWELL 4, 2, 3, 1) each driving a mux model.
// Expected samples are queued when stimulus is applied and popped on every y_valid.
module tb_mux_scan_sequencer;

    typedef struct packed {
        logic [1:0] dut;
        logic [1:0] ch;
        logic       yq;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic       en_v   [4];
    logic [3:0] req_v  [4];
    logic [3:0] data_v [4];
    logic       yin_v  [4];
    logic       s1_v   [4];
    logic       s0_v   [4];
    logic [3:0] gnt_v  [4];
    logic       busy_v [4];
    logic       yq_v   [4];
    logic [1:0] ych_v  [4];
    logic       yv_v   [4];

    sb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux model: y = i[{S1,S0}] with i0..i3 = data_v[d][0..3].
    assign yin_v[0] = data_v[0][{s1_v[0], s0_v[0]}];
    assign yin_v[1] = data_v[1][{s1_v[1], s0_v[1]}];
    assign yin_v[2] = data_v[2][{s1_v[2], s0_v[2]}];
    assign yin_v[3] = data_v[3][{s1_v[3], s0_v[3]}];

    mux_scan_sequencer #(.DWELL(4), .CNT_W(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .req(req_v[0]), .y_in(yin_v[0]),
        .S1(s1_v[0]), .S0(s0_v[0]), .grant(gnt_v[0]), .busy(busy_v[0]),
        .y_q(yq_v[0]), .y_ch(ych_v[0]), .y_valid(yv_v[0]));
    mux_scan_sequencer #(.DWELL(2), .CNT_W(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .req(req_v[1]), .y_in(yin_v[1]),
        .S1(s1_v[1]), .S0(s0_v[1]), .grant(gnt_v[1]), .busy(busy_v[1]),
        .y_q(yq_v[1]), .y_ch(ych_v[1]), .y_valid(yv_v[1]));
    mux_scan_sequencer #(.DWELL(3), .CNT_W(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .req(req_v[2]), .y_in(yin_v[2]),
        .S1(s1_v[2]), .S0(s0_v[2]), .grant(gnt_v[2]), .busy(busy_v[2]),
        .y_q(yq_v[2]), .y_ch(ych_v[2]), .y_valid(yv_v[2]));
    mux_scan_sequencer #(.DWELL(1), .CNT_W(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[3]), .req(req_v[3]), .y_in(yin_v[3]),
        .S1(s1_v[3]), .S0(s0_v[3]), .grant(gnt_v[3]), .busy(busy_v[3]),
        .y_q(yq_v[3]), .y_ch(ych_v[3]), .y_valid(yv_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk_state(input string tag, input int d, input logic [3:0] g_exp, input logic yv_exp);
        chk({tag, "_grant"}, 32'(gnt_v[d]), 32'(g_exp));
        chk({tag, "_busy"}, 32'(busy_v[d]), 32'(g_exp != 4'd0));
        chk({tag, "_y_valid"}, 32'(yv_v[d]), 32'(yv_exp));
        if (g_exp != 4'd0) chk({tag, "_sel"}, 32'({s1_v[d], s0_v[d]}), 32'(enc(g_exp)));
    endtask

    task automatic push(input int d, input int ch, input logic yq);
        sb_t e;
        e.dut = 2'(d);
        e.ch  = 2'(ch);
        e.yq  = yq;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every y_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        sb_t e;
        for (int i = 0; i < 4; i++) begin
            if (yv_v[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("sb_unexpected_y_valid_dut%0d", i), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_dut", 32'(i), 32'(e.dut));
                    chk("sb_y_ch", 32'(ych_v[i]), 32'(e.ch));
                    chk("sb_y_q", 32'(yq_v[i]), 32'(e.yq));
                end
            end
        end
    end

    initial begin
        logic [3:0] g;
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            en_v[d] = 1'b0; req_v[d] = 4'd0; data_v[d] = 4'd0;
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk_state($sformatf("reset_d%0d", d), d, 4'd0, 1'b0);
            chk($sformatf("reset_s_d%0d", d), 32'({s1_v[d], s0_v[d]}), 32'd0);
            chk($sformatf("reset_yq_d%0d", d), 32'(yq_v[d]), 32'd0);
            chk($sformatf("reset_ych_d%0d", d), 32'(ych_v[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single channel ch2, then wrap from ptr=3 with req=0011: ch0, ch1, ch0.
        en_v[0] = 1'b1; req_v[0] = 4'b0100; data_v[0] = 4'b1111;
        push(0, 2, 1'b1);
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (n <= 8)       g = 4'b0100;
            else if (n <= 12) g = 4'b0001;
            else if (n <= 16) g = 4'b0010;
            else if (n <= 20) g = 4'b0001;
            else              g = 4'b0000;
            chk_state($sformatf("single_c%0d", n), 0, g, (n == 5 || n == 9 || n == 13 || n == 17 || n == 21));
            if (n == 5) begin
                req_v[0] = 4'b0011; data_v[0] = 4'b0101;
                push(0, 2, 1'b1); push(0, 0, 1'b1); push(0, 1, 1'b0); push(0, 0, 1'b1);
            end
            if (n == 17) req_v[0] = 4'b0000;
        end
        chk("idle_sel_hold", 32'({s1_v[0], s0_v[0]}), 32'd0);

        // Reset in the middle of a dwell: no sample, pointer back to 0.
        @(negedge clk);
        req_v[0] = 4'b0001;
        @(negedge clk);
        chk_state("pre_rst", 0, 4'b0001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; req_v[0] = 4'b0000;
        #1;
        chk_state("mid_rst", 0, 4'b0000, 1'b0);
        chk("mid_rst_s", 32'({s1_v[0], s0_v[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk_state($sformatf("post_rst_c%0d", n), 0, 4'b0000, 1'b0);
        end
        req_v[0] = 4'b1111;
        push(0, 0, 1'b1);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk_state($sformatf("ptr_rst_c%0d", n), 0, (n <= 4) ? 4'b0001 : 4'b0000, n == 5);
            if (n == 1) req_v[0] = 4'b0000;
        end

        // Round robin, DWELL=2, i0..i3 = 1,0,1,1.
        en_v[1] = 1'b1; req_v[1] = 4'b1111; data_v[1] = 4'b1101;
        push(1, 0, 1'b1); push(1, 1, 1'b0); push(1, 2, 1'b1); push(1, 3, 1'b1); push(1, 0, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            g = (n <= 10) ? (4'b0001 << (((n - 1) / 2) % 4)) : 4'b0000;
            chk_state($sformatf("rr_c%0d", n), 1, g, (n >= 3 && n <= 11 && (n % 2) == 1));
            if (n == 10) req_v[1] = 4'b0000;
        end

        // One-cycle request, en dropped mid-dwell, DWELL=3.
        en_v[2] = 1'b1; req_v[2] = 4'b0001; data_v[2] = 4'b0001;
        push(2, 0, 1'b1);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk_state($sformatf("drop_c%0d", n), 2, (n <= 3) ? 4'b0001 : 4'b0000, n == 4);
            if (n == 1) begin
                req_v[2] = 4'b0000; en_v[2] = 1'b0;
            end
        end
        chk("drop_sel_hold", 32'({s1_v[2], s0_v[2]}), 32'd0);
        chk("drop_yq_hold", 32'(yq_v[2]), 32'd1);
        chk("drop_ych_hold", 32'(ych_v[2]), 32'd0);

        // DWELL=1 with req=1010: alternate ch1/ch3 every cycle, y_valid continuous.
        en_v[3] = 1'b1; req_v[3] = 4'b1010; data_v[3] = 4'b0010;
        for (int k = 0; k < 8; k++) push(3, (k % 2 == 0) ? 1 : 3, (k % 2 == 0));
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            g = (n > 8) ? 4'b0000 : ((n % 2 == 1) ? 4'b0010 : 4'b1000);
            chk_state($sformatf("d1_c%0d", n), 3, g, (n >= 2 && n <= 9));
            if (n == 8) req_v[3] = 4'b0000;
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
